// File: rtl/wb_serial_rx_if.sv
// wb_serial_rx_if: Wishbone classic bus bundle for wb_serial_rx (signal names seen from the slave side).
interface wb_serial_rx_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  modport slave (input CYC_I, STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);
  modport master (output CYC_I, STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
endinterface

// File: rtl/wb_serial_rx.sv
// wb_serial_rx: Wishbone slave deserializing an LSB-first serial stream into a FIFO; define WB_SERIAL_RX_IRQ_EN to add irq_o.
module wb_serial_rx #(
  parameter int WORD_W       = 10,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  wb_serial_rx_if.slave wb,
  input  logic          ser_ena_i,
  input  logic          ser_data_i
`ifdef WB_SERIAL_RX_IRQ_EN
  ,
  output logic          irq_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WORD_W);
  typedef enum logic [1:0] {IDLE, HALF, SHIFT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [31:0] dat_q, dat_d, rdata;
  logic ena_prev_q, enable_q, enable_d, ovf_q, ovf_d, ack_q, ack_d, irq_mask;
  logic req, wr_ctrl, empty, full, push, pop, push_ok, unused;
  assign unused  = ^{wb.ADR_I[31:4], wb.ADR_I[1:0], wb.DAT_I[31:2]};
  assign req     = wb.CYC_I & wb.STB_I & ~ack_q;
  assign wr_ctrl = req & wb.WE_I & (wb.ADR_I[3:2] == 2'd2);
  assign pop     = req & ~wb.WE_I & (wb.ADR_I[3:2] == 2'd0) & ~empty;
  assign empty   = count_q == '0;
  assign full    = count_q == (AW+1)'(FIFO_DEPTH);
  assign push_ok = push & (~full | pop);
  assign rdata   = wb.ADR_I[3:2] == 2'd0 ? (empty ? '0 : 32'(mem_q[rd_ptr_q])) :
                   wb.ADR_I[3:2] == 2'd1 ? {20'd0, 4'(count_q), 5'd0, ovf_q, full, empty} :
                   wb.ADR_I[3:2] == 2'd2 ? {29'd0, irq_mask, 1'b0, enable_q} : '0;
  assign wb.ACK_O = ack_q;
  assign wb.DAT_O = dat_q;
  // Start on a falling enable edge; sample each bit mid-way, first one half a bit after the edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    if (state_q == IDLE) begin
      if (ena_prev_q && !ser_ena_i && enable_q) begin
        state_d = HALF;
        cnt_d   = '0;
        idx_d   = '0;
      end
    end else if (ser_ena_i || !enable_q) begin
      state_d = IDLE;
    end else if (state_q == HALF) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(CLKS_PER_BIT/2 - 1)) begin
        shift_d[0] = ser_data_i;
        cnt_d      = '0;
        idx_d      = IW'(1);
        state_d    = SHIFT;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
        cnt_d          = '0;
        shift_d[idx_q] = ser_data_i;
        push           = idx_q == IW'(WORD_W - 1);
        idx_d          = push ? '0 : idx_q + 1'b1;
      end
    end
  end
  // A push into a full FIFO survives only when a pop frees the slot on the same edge; set beats W1C.
  always_comb begin
    ack_d    = req;
    dat_d    = req ? rdata : dat_q;
    enable_d = wr_ctrl ? wb.DAT_I[0] : enable_q;
    ovf_d    = (push & full & ~pop) | (ovf_q & ~(wr_ctrl & wb.DAT_I[1]));
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      ena_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      enable_q   <= 1'b1;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      ena_prev_q <= ser_ena_i;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      enable_q   <= enable_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end
  always_ff @(posedge CLK_I) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_d;
  end
`ifdef WB_SERIAL_RX_IRQ_EN
  logic irq_mask_q, irq_mask_d, irq_q, irq_d;
  assign irq_mask   = irq_mask_q;
  assign irq_mask_d = wr_ctrl ? wb.DAT_I[2] : irq_mask_q;
  assign irq_d      = irq_mask_q & (~empty | ovf_q);
  assign irq_o      = irq_q;
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end
`else
  assign irq_mask = 1'b0;
`endif
endmodule

// File: doc/wb_serial_rx.md
Name: wb_serial_rx

Overview:
- Wishbone classic slave that deserializes the single-bit stream (data + enable) produced by the team's Wishbone-to-serial transmitter.
- Assembles WORD_W-bit words LSB-first and buffers them in a small FIFO.
- Exposes data, status and control registers to a Wishbone initiator.
- Sits at the far end of the serial link, so a bench or SoC master can read back what the transmitter sent.

Parameters:
- WORD_W, 10, bits per serial word.
- CLKS_PER_BIT, 4, CLK_I cycles per serial bit; even, >= 2.
- FIFO_DEPTH, 8, receive FIFO entries; power of two.

Ports:
- CLK_I  in  1  system clock; all logic on rising edge.
- RST_I  in  1  synchronous, active-high reset.
- CYC_I  in  1  Wishbone cycle.
- STB_I  in  1  Wishbone strobe.
- WE_I  in  1  Wishbone write enable.
- ADR_I  in  32  byte address; only ADR_I[3:2] decoded.
- DAT_I  in  32  write data.
- DAT_O  out  32  read data.
- ACK_O  out  1  Wishbone acknowledge.
- ser_ena_i  in  1  serial enable; high = idle, falling edge = stream start. Synchronous to CLK_I.
- ser_data_i  in  1  serial data, LSB first.

Behaviour:
- Reset (RST_I=1 at a clock edge):
  - ACK_O=0, DAT_O=0.
  - FIFO emptied; overflow flag cleared.
  - CTRL.enable=1.
  - Receiver FSM forced to IDLE; any partial word is discarded.
- Registers (ADR_I[3:2]):
  - 0 DATA, read-only. Read returns FIFO head zero-extended and pops it. Read when empty returns 0 with no pop. Writes ignored.
  - 1 STATUS, read-only. bit0 empty, bit1 full, bit2 overflow (sticky), bits[11:8] count. Writes ignored.
  - 2 CTRL. bit0 enable, read/write. bit1 write-1-to-clear overflow; reads as 0.
  - 3 reserved. Reads 0; writes ignored; still ACKed.
- Wishbone handshake:
  - When CYC_I&STB_I&!ACK_O at edge N, ACK_O=1 during cycle N+1 for exactly one cycle, with DAT_O valid in that cycle. Register write and FIFO pop take effect at edge N.
  - If STB_I is still high after the ACK cycle, it is a new access and is ACKed again two cycles later.
  - DAT_O is held otherwise.
  - Latency is fixed at 1 cycle; no wait states, no ERR/RTY.
- Receiver FSM:
  - IDLE:
    - Track ser_ena_i from the previous cycle.
    - On a 1->0 transition with enable=1, go to HALF with counter=0 and bit index=0.
    - With enable=0, edges are ignored.
  - HALF: wait CLKS_PER_BIT/2 cycles (mid-bit), then sample bit 0 and go to SHIFT.
  - SHIFT:
    - Every CLKS_PER_BIT cycles, sample ser_data_i into shift[bit index].
    - After bit WORD_W-1, push the word and restart at bit 0 with no gap. Words stream back-to-back while ser_ena_i stays low.
  - ser_ena_i=1 in HALF/SHIFT: discard the partial word at that edge and return to IDLE. Words already pushed are kept.
  - CTRL.enable cleared mid-word: behaves as abort; return to IDLE.
- FIFO boundaries:
  - Push when full and no pop in the same cycle: word dropped, overflow=1.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: the pop returns 0; the push is stored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow set and W1C clear in the same cycle: set wins.

Optional Feature:
- Macro WB_SERIAL_RX_IRQ_EN.
- Defined:
  - Adds output port irq_o (1 bit) = CTRL.bit2 & (!empty | overflow), registered.
  - CTRL.bit2 is irq mask, reset 0, read/write.
  - irq_o resets to 0.
- Undefined:
  - No irq_o port.
  - CTRL.bit2 reads 0 and writes are ignored.

Test Plan:
- Reset check: hold RST_I 2 cycles. DATA reads 0; STATUS=0x001 (empty); CTRL reads 0x1; ACK_O rises exactly one cycle after each STB.
- Single word: drive ser_ena_i 1->0, then 10'h2CD LSB-first at CLKS_PER_BIT=4, then ser_ena_i=1. STATUS count=1; DATA read=0x000002CD; next STATUS=0x001.
- Back-to-back stream: hold ser_ena_i low for 3 words 0x3FF, 0x000, 0x155. Reads return them in order; no bit slip at word boundaries.
- Overflow: stream 9 words into FIFO_DEPTH=8. STATUS shows full, overflow, count 8. The first 8 words read back; the 9th is lost. Writing CTRL=0x3 clears overflow and keeps enable.
- Abort: raise ser_ena_i after 5 bits of a word. Nothing is pushed. The next full frame 0x1A5 reads back correctly. Repeat with RST_I asserted mid-word: FIFO empty, FSM IDLE.
- Simultaneous push/pop at full: pop DATA on the same edge the 9th word completes. Count stays 8; no overflow; order preserved.
